// File: rtl/sparse_sample_unpacker_if.sv
// -----------------------------------------------------------------------------
// Axis_If
//   Minimal AXI-stream style bundle used by the sparse sample unpacker.
//   WIDTH sets the payload width.
//   master: drives valid/last/data, samples ready.
//   slave : samples valid/last/data, drives ready.
// -----------------------------------------------------------------------------
interface Axis_If #(
  parameter int WIDTH = 128
) ();
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/sparse_sample_unpacker.sv
// -----------------------------------------------------------------------------
// sparse_sample_unpacker
//   Decodes the sparse_sample_buffer readout stream (timestamp section, then
//   data section; every bank is a header {section, channel, count} followed by
//   ceil(count/K) packed payload words) back into per-channel timestamp and
//   parallel-sample streams tagged with their channel index.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   data_in            Axis_If slave, AXI_MM_WIDTH-wide readout stream
//   timestamp_out      Axis_If master, one timestamp per beat, last = bank end
//   timestamp_channel  channel tag, qualified by timestamp_out.valid
//   sample_out         Axis_If master, one parallel-sample entry per beat
//   sample_channel     channel tag, qualified by sample_out.valid
//   readout_done       one-cycle pulse after a last-terminated readout drains
//   format_error       sticky malformed-stream flag, cleared by the first
//                      header of the next readout
//   entry_count        (only with SPARSE_UNPACKER_STATS_EN) saturating
//                      per-channel [ch][0=timestamp,1=data] emitted-entry count
//
// Optional feature macro: SPARSE_UNPACKER_STATS_EN
// -----------------------------------------------------------------------------
module sparse_sample_unpacker #(
  parameter  int AXI_MM_WIDTH      = 128,
  parameter  int TIMESTAMP_WIDTH   = 64,
  parameter  int SAMPLE_WIDTH      = 16,
  parameter  int PARALLEL_SAMPLES  = 4,
  parameter  int CHANNELS          = 8,
  parameter  int DATA_BUFFER_DEPTH = 1024,
  localparam int CH_W              = $clog2(CHANNELS),
  localparam int COUNT_W           = $clog2(DATA_BUFFER_DEPTH*CHANNELS) + 1
) (
  input  logic            clk,
  input  logic            reset,
  Axis_If.slave           data_in,
  Axis_If.master          timestamp_out,
  output logic [CH_W-1:0] timestamp_channel,
  Axis_If.master          sample_out,
  output logic [CH_W-1:0] sample_channel,
  output logic            readout_done,
  output logic            format_error
`ifdef SPARSE_UNPACKER_STATS_EN
  ,
  output logic [COUNT_W-1:0] entry_count [CHANNELS][2]
`endif
);

  localparam int ENTRY_W = PARALLEL_SAMPLES * SAMPLE_WIDTH;
  localparam int K_TS    = AXI_MM_WIDTH / TIMESTAMP_WIDTH;
  localparam int K_DS    = AXI_MM_WIDTH / ENTRY_W;
  localparam int K_MAX   = (K_TS > K_DS) ? K_TS : K_DS;
  localparam int SLOT_W  = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  localparam logic [COUNT_W-1:0] K_TS_C   = COUNT_W'(K_TS);
  localparam logic [COUNT_W-1:0] K_DS_C   = COUNT_W'(K_DS);
  localparam logic [SLOT_W-1:0]  TS_SLOTS = SLOT_W'(K_TS - 1);
  localparam logic [SLOT_W-1:0]  DS_SLOTS = SLOT_W'(K_DS - 1);

  typedef enum logic [1:0] {S_HEADER, S_LOAD, S_EMIT} state_t;

  state_t                  state;
  logic                    in_ready;
  logic                    sec;          // 0 = timestamp, 1 = data
  logic [CH_W-1:0]         ch;
  logic [COUNT_W-1:0]      remaining;    // entries still owed, current included
  logic [SLOT_W-1:0]       slot;
  logic [AXI_MM_WIDTH-1:0] hold;
  logic                    out_valid;
  logic                    last_seen;    // data_in.last arrived in this bank
  logic                    seen_data;    // a data header was seen this readout
  logic                    new_readout;  // readout_done fired, next header starts fresh

  // Header fields and handshake decode.
  logic               in_fire, hdr_fire, out_fire, out_ready, last_beat, sec_regress;
  logic               hdr_sec;
  logic [CH_W-1:0]    hdr_ch;
  logic [COUNT_W-1:0] hdr_cnt, k_sec;
  logic [SLOT_W-1:0]  slot_max;

  assign hdr_cnt     = data_in.data[COUNT_W-1:0];
  assign hdr_ch      = data_in.data[COUNT_W +: CH_W];
  assign hdr_sec     = data_in.data[AXI_MM_WIDTH-1];
  assign in_fire     = data_in.valid & in_ready;
  assign hdr_fire    = in_fire & (state == S_HEADER);
  assign k_sec       = sec ? K_DS_C : K_TS_C;
  assign slot_max    = sec ? DS_SLOTS : TS_SLOTS;
  assign out_ready   = sec ? sample_out.ready : timestamp_out.ready;
  assign out_fire    = out_valid & out_ready;
  assign last_beat   = (remaining == COUNT_W'(1));
  // Timestamps after data inside one readout means the stream is out of order.
  assign sec_regress = ~hdr_sec & seen_data & ~new_readout;

  // NOTE: ready comes from a flop rather than decoding the state, so it stays
  // low during reset and rises on the first clock after reset is released.
  assign data_in.ready = in_ready;

  assign timestamp_out.valid = out_valid & ~sec;
  assign timestamp_out.last  = out_valid & ~sec & last_beat;
  assign timestamp_out.data  = hold[slot*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH];
  assign timestamp_channel   = ch;

  assign sample_out.valid = out_valid & sec;
  assign sample_out.last  = out_valid & sec & last_beat;
  assign sample_out.data  = hold[slot*ENTRY_W +: ENTRY_W];
  assign sample_channel   = ch;

  // NOTE: every state register is updated with non-blocking assignments so all
  // flops in this block see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_HEADER;
      in_ready     <= 1'b0;
      sec          <= 1'b0;
      ch           <= '0;
      remaining    <= '0;
      slot         <= '0;
      hold         <= '0;
      out_valid    <= 1'b0;
      last_seen    <= 1'b0;
      seen_data    <= 1'b0;
      new_readout  <= 1'b0;
      readout_done <= 1'b0;
      format_error <= 1'b0;
    end else begin
      readout_done <= 1'b0;
      case (state)
        S_HEADER: begin
          in_ready <= 1'b1;
          if (hdr_fire) begin
            sec          <= hdr_sec;
            ch           <= hdr_ch;
            remaining    <= hdr_cnt;
            last_seen    <= 1'b0;
            seen_data    <= hdr_sec | (seen_data & ~new_readout);
            format_error <= (format_error & ~new_readout) | sec_regress
                          | (data_in.last & (hdr_cnt != '0));
            new_readout  <= 1'b0;
            if (data_in.last) begin
              // Readout ends on a header: empty bank, or payload that never came.
              readout_done <= 1'b1;
              new_readout  <= 1'b1;
            end else if (hdr_cnt != '0) begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            hold      <= data_in.data;
            slot      <= '0;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            last_seen <= data_in.last;
            state     <= S_EMIT;
            if (data_in.last && (remaining > k_sec)) begin
              // Stream ended early: emit this word in full and close the bank.
              remaining    <= k_sec;
              format_error <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_fire) begin
            remaining <= remaining - COUNT_W'(1);
            if (last_beat) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              slot      <= '0;
              state     <= S_HEADER;
              if (last_seen) begin
                readout_done <= 1'b1;
                new_readout  <= 1'b1;
              end
            end else if (slot == slot_max) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              slot      <= '0;
              state     <= S_LOAD;
            end else begin
              slot <= slot + SLOT_W'(1);
            end
          end
        end
        default: state <= S_HEADER;
      endcase
    end
  end

`ifdef SPARSE_UNPACKER_STATS_EN
  // NOTE: the counters are a small register array, not RAM, so they take the
  // asynchronous reset like every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        entry_count[c][0] <= '0;
        entry_count[c][1] <= '0;
      end
    end else if (hdr_fire && new_readout) begin
      for (int c = 0; c < CHANNELS; c++) begin
        entry_count[c][0] <= '0;
        entry_count[c][1] <= '0;
      end
    end else if (out_fire && (entry_count[ch][sec] != '1)) begin
      entry_count[ch][sec] <= entry_count[ch][sec] + COUNT_W'(1);
    end
  end
`endif

endmodule
